// File: rtl/spi_wb_slave_regs.sv
// Wishbone register file for the SPI core: TX/RX data, CTRL, DIVIDER and SS registers.
// Optional macro SPI_WB_ERR_EN: illegal accesses terminate with err_o instead of ack_o.
module spi_wb_slave_regs #(
  parameter int unsigned SS_NB   = 8,
  parameter logic [15:0] DIV_RST = 16'hFFFF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [4:0]         adr_in,
  input  logic [31:0]        dat_in,
  input  logic [3:0]         sel_in,
  input  logic               we_in,
  input  logic               cyc_in,
  input  logic               stb_in,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  output logic               err_o,
  output logic               int_o,
  input  logic [127:0]       rx_data_in,
  input  logic               busy_in,
  input  logic               done_in,
  output logic [127:0]       tx_data_o,
  output logic [13:0]        ctrl_o,
  output logic [15:0]        divider_o,
  output logic [SS_NB-1:0]   ss_o
);

  logic [31:0]      r_dat;
  logic             r_ack;
  logic             r_int;
  logic [127:0]     r_tx;
  logic [13:0]      r_ctrl;
  logic [15:0]      r_div;
  logic [SS_NB-1:0] r_ss;

  logic [2:0]  w_word;
  logic        w_valid;
  logic        w_illegal;
  logic        w_locked;
  logic        w_wr;
  logic        w_wr_tx;
  logic        w_wr_ctrl;
  logic        w_wr_div;
  logic        w_wr_ss;
  logic [31:0] w_rdata;
  logic [31:0] w_ss_ext;

`ifdef SPI_WB_ERR_EN
  logic r_err;
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign w_word    = adr_in[4:2];
  assign w_valid   = cyc_in & stb_in & ~ack_o & ~err_o;
  assign w_illegal = (adr_in[1:0] != 2'b00) | (w_word == 3'd7);
  // TX and CTRL are frozen while a transfer is pending or running
  assign w_locked  = busy_in | r_ctrl[8];
  assign w_wr      = w_valid & we_in & ~w_illegal;
  assign w_wr_tx   = w_wr & ~w_word[2] & ~w_locked;
  assign w_wr_ctrl = w_wr & (w_word == 3'd4) & ~w_locked;
  assign w_wr_div  = w_wr & (w_word == 3'd5);
  assign w_wr_ss   = w_wr & (w_word == 3'd6);

  always_comb begin
    w_ss_ext = '0;
    for (int i = 0; i < SS_NB; i++) begin
      w_ss_ext[i] = r_ss[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      3'd0:    w_rdata = rx_data_in[31:0];
      3'd1:    w_rdata = rx_data_in[63:32];
      3'd2:    w_rdata = rx_data_in[95:64];
      3'd3:    w_rdata = rx_data_in[127:96];
      3'd4:    w_rdata = {18'b0, r_ctrl};
      3'd5:    w_rdata = {16'b0, r_div};
      3'd6:    w_rdata = w_ss_ext;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_dat  <= '0;
      r_ack  <= 1'b0;
`ifdef SPI_WB_ERR_EN
      r_err  <= 1'b0;
`endif
      r_int  <= 1'b0;
      r_tx   <= '0;
      r_ctrl <= '0;
      r_div  <= DIV_RST;
      r_ss   <= '0;
    end else begin
`ifdef SPI_WB_ERR_EN
      r_ack <= w_valid & ~w_illegal;
      r_err <= w_valid & w_illegal;
`else
      r_ack <= w_valid;
`endif
      if (w_valid) begin
        r_dat <= (we_in | w_illegal) ? 32'h0 : w_rdata;
      end

      if (w_wr_tx) begin
        for (int b = 0; b < 4; b++) begin
          if (sel_in[b]) begin
            r_tx[32*int'(w_word[1:0]) + 8*b +: 8] <= dat_in[8*b +: 8];
          end
        end
      end

      // Bit 7 is reserved and never written
      if (w_wr_ctrl) begin
        if (sel_in[0]) r_ctrl[6:0]  <= dat_in[6:0];
        if (sel_in[1]) r_ctrl[13:8] <= dat_in[13:8];
      end
      // Completion beats a simultaneous GO write
      if (done_in) begin
        r_ctrl[8] <= 1'b0;
      end

      if (w_wr_div) begin
        if (sel_in[0]) r_div[7:0]  <= dat_in[7:0];
        if (sel_in[1]) r_div[15:8] <= dat_in[15:8];
      end

      if (w_wr_ss) begin
        for (int i = 0; i < SS_NB; i++) begin
          if (sel_in[i/8]) r_ss[i] <= dat_in[i];
        end
      end

      if (done_in && r_ctrl[12]) begin
        r_int <= 1'b1;
      end else if (w_valid) begin
        r_int <= 1'b0;
      end
    end
  end

  assign dat_o     = r_dat;
  assign ack_o     = r_ack;
  assign int_o     = r_int;
  assign tx_data_o = r_tx;
  assign ctrl_o    = r_ctrl;
  assign divider_o = r_div;
  assign ss_o      = r_ss;

endmodule

// File: doc/spi_wb_slave_regs.md
Name: spi_wb_slave_regs

Overview:
- Wishbone slave register file of the SPI core; directly consumes the cyc/stb/we/adr/dat/sel stream produced by the bus master.
- Decodes 5-bit byte addresses into TX/RX data, control, divider and slave-select registers.
- Generates single-pulse ack/err, holds the GO bit until the shift engine reports completion, and raises the interrupt.
- Exports register contents to the SPI shift/clock-gen stages.

Parameters:
- SS_NB, 8, number of slave-select lines (1..32).
- DIV_RST, 16'hFFFF, reset value of DIVIDER register.

Ports:
- clk_in  input  1  system clock, all logic on posedge.
- rst_in  input  1  asynchronous, active-low reset.
- adr_in  input  5  byte address from master.
- dat_in  input  32  write data.
- sel_in  input  4  byte lanes; bit i enables dat_in[8i+7:8i].
- we_in  input  1  1 = write, 0 = read.
- cyc_in  input  1  bus cycle valid.
- stb_in  input  1  strobe.
- dat_o  output  32  read data, valid with ack_o.
- ack_o  output  1  normal termination.
- err_o  output  1  error termination (see optional feature).
- int_o  output  1  transfer-complete interrupt.
- rx_data_in  input  128  received shift data from shift engine.
- busy_in  input  1  shift engine transfer in progress.
- done_in  input  1  one-cycle pulse at transfer end.
- tx_data_o  output  128  TX0..TX3 concatenated, TX0 = bits 31:0.
- ctrl_o  output  14  CTRL register.
- divider_o  output  16  DIVIDER register.
- ss_o  output  SS_NB  SS register contents (raw; polarity handled downstream).

Behaviour:
- Reset (rst_in low, asynchronous): ack_o=0, err_o=0, int_o=0, dat_o=0, TX0..3=0, CTRL=0, DIVIDER=DIV_RST, SS=0.
- Register map (word index = adr_in[4:2]):
  - 0x00..0x0C: read RX0..RX3 (rx_data_in slices); write TX0..TX3.
  - 0x10: CTRL. [6:0] CHAR_LEN, [7] reserved (reads 0), [8] GO, [9] RX_NEG, [10] TX_NEG, [11] LSB, [12] IE, [13] ASS.
  - 0x14: DIVIDER[15:0].
  - 0x18: SS[SS_NB-1:0].
  - 0x1C: illegal.
- Access valid = cyc_in & stb_in & ~ack_o & ~err_o.
  - Termination is registered: ack_o/err_o assert the cycle after a valid access and are always one-cycle pulses.
  - A master holding stb gets one termination every 2 cycles.
  - Read data is registered into dat_o in the same edge as ack_o; unused upper bits read 0.
- Illegal access: adr_in[1:0] != 0, or word index 7.
- Writes are byte-lane masked by sel_in. Bits beyond a register's width are ignored. sel_in = 0 writes nothing but is still acked.
- Writes to TX0..3 or CTRL while busy_in=1 or GO=1 are dropped but acked. DIVIDER and SS are always writable.
- GO is set by a CTRL write with dat_in[8]=1 (lane 1 enabled). It clears on the edge after done_in. done_in wins over a simultaneous GO write.
- int_o:
  - Sets on done_in when CTRL[12]=1.
  - Clears on the edge after any valid access.
  - Set wins over a simultaneous clear.
- Reset mid-transfer clears GO immediately. Any pending ack is lost, with no termination pulse.
- A read of RX while busy_in=1 returns current rx_data_in; no buffering.

Optional Feature:
- Macro: SPI_WB_ERR_EN.
- Defined: illegal accesses terminate with err_o (one-cycle pulse) instead of ack_o; writes dropped; dat_o=0.
- Undefined: err_o tied 0; illegal accesses terminate with ack_o, reads return 0, writes dropped.

Test Plan:
- Reset, then read 0x14 and 0x10 -> ack one cycle after stb; dat_o=32'h0000FFFF, then 32'h0.
- Write 0x00 dat=32'hA5A5_1234 sel=4'b0011, read 0x00 (via tx_data_o) -> tx_data_o[31:0]=32'h0000_1234.
- Write CTRL=32'h0000_1108 (GO=1, IE=1, CHAR_LEN=8), pulse done_in -> GO clears next edge, int_o=1; next access clears int_o.
- With GO=1, write TX1=32'hDEADBEEF -> ack pulse, tx_data_o[63:32] unchanged; write SS=8'h04 -> ss_o=8'h04.
- Access adr=5'h1C and adr=5'h02 -> SPI_WB_ERR_EN defined: err_o pulse, ack_o=0; undefined: ack_o pulse, dat_o=0; no register changes.
- Assert rst_in low mid-write (stb high, before ack) -> all outputs at reset values asynchronously, no ack after release until new stb.
